// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller downstream of traffic_light: latches button requests,
// grants WALK on entry to vehicle RED, then a flashing clearance, aborting if RED is lost.
//
// state | meaning
// IDLE  | solid don't-walk, waiting for red entry with a pending request
// WALK  | walk lamp on for WALK_CYCLES cycles
// CLEAR | flashing don't-walk with countdown for CLEAR_CYCLES cycles
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 6,
    parameter int BLINK_HALF   = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [1:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             abort
);

    localparam logic [1:0]       RED        = 2'b00;
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {IDLE, WALK, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] bcnt, bcnt_nxt;
    logic             bph, bph_nxt;
    logic [1:0]       btn_sync;
    logic             btn_q;
    logic [1:0]       light_q;
    logic             req_nxt;
    logic             abort_nxt;
    logic             btn_rise;
    logic             light_red;
    logic             red_entry;

    assign btn_rise  = btn_sync[1] & ~btn_q;
    assign light_red = (light == RED);
    assign red_entry = light_red && (light_q != RED);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            cnt         <= '0;
            bcnt        <= '0;
            bph         <= 1'b0;
            btn_sync    <= 2'b00;
            btn_q       <= 1'b0;
            light_q     <= RED;
            req_pending <= 1'b0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= '0;
            abort       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bcnt        <= bcnt_nxt;
            bph         <= bph_nxt;
            btn_sync    <= {btn_sync[0], ped_btn};
            btn_q       <= btn_sync[1];
            light_q     <= light;
            req_pending <= req_nxt;
            // lamps are registered from the next state so they change with it
            walk        <= (state_nxt == WALK);
            dont_walk   <= (state_nxt == CLEAR) ? ~bph_nxt : (state_nxt != WALK);
            countdown   <= (state_nxt == CLEAR) ? cnt_nxt : '0;
            abort       <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bcnt_nxt  = bcnt;
        bph_nxt   = bph;
        abort_nxt = 1'b0;
        req_nxt   = req_pending;

        if (btn_rise && state != WALK)
            req_nxt = 1'b1;

        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                bcnt_nxt = '0;
                bph_nxt  = 1'b0;
                // uses the registered flag, so a request landing this cycle waits
                if (red_entry && req_pending) begin
                    state_nxt = WALK;
                    cnt_nxt   = WALK_LOAD;
                    req_nxt   = 1'b0;
                end
            end
            WALK: begin
                if (!light_red) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = CLEAR_LOAD;
                    bcnt_nxt  = '0;
                    bph_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CLEAR: begin
                if (!light_red || cnt == '0) begin
                    state_nxt = IDLE;
                    abort_nxt = !light_red;
                    cnt_nxt   = '0;
                    bcnt_nxt  = '0;
                    bph_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (bcnt == BLINK_LAST) begin
                        bcnt_nxt = '0;
                        bph_nxt  = ~bph;
                    end else begin
                        bcnt_nxt = bcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
